// File: rtl/i2c_pkg.sv
// Shared types for the synchronous I2C target: FSM state encoding and R/W bit values.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } i2c_state_e;

  localparam logic RwWrite = 1'b0;
  localparam logic RwRead  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with edge, START and STOP detection on the synchronised levels.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_now, sda_now;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_now;
      sda_prev_q <= sda_now;
    end
  end

  assign scl_now    = scl_sync_q[SYNC_STAGES-1];
  assign sda_now    = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_now;
  assign scl_rise_o = scl_now & ~scl_prev_q;
  assign scl_fall_o = ~scl_now & scl_prev_q;
  assign start_o    = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
  assign stop_o     = scl_now & scl_prev_q & ~sda_prev_q & sda_now;

endmodule

// File: rtl/i2c_target_sync.sv
// Oversampled 7-bit-addressed I2C target moving DATA_BYTES-wide words to and from core logic.
module i2c_target_sync
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDRESS     = 7'h2A,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  input  logic [8*DATA_BYTES-1:0] data_fetch,
  output logic [8*DATA_BYTES-1:0] data_send,
  output logic                    rx_valid,
  output logic                    tx_done,
  output logic                    busy
);

  localparam int unsigned W    = 8 * DATA_BYTES;
  localparam int unsigned IdxW = $clog2(DATA_BYTES) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BYTES - 1);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  i2c_state_e      state_q;
  logic [3:0]      bit_cnt_q;
  logic [IdxW-1:0] byte_idx_q;
  logic [6:0]      addr_sr_q;
  logic            rw_q;
  logic            ack_on_q;
  logic [W-1:0]    rx_sr_q, tx_sr_q;
  logic            sda_oe_q, rx_valid_q, tx_done_q, busy_q;
  logic [W-1:0]    data_send_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd7;
      byte_idx_q  <= '0;
      addr_sr_q   <= '0;
      rw_q        <= RwWrite;
      ack_on_q    <= 1'b0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      data_send_q <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_done_q  <= 1'b0;
      // Bus conditions override any SCL edge seen in the same cycle.
      if (stop) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start) begin
        state_q    <= StAddr;
        bit_cnt_q  <= 4'd7;
        byte_idx_q <= '0;
        ack_on_q   <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        unique case (state_q)
          StAddr: begin
            if (scl_rise) begin
              if (bit_cnt_q == 4'd0) begin
                rw_q     <= sda;
                ack_on_q <= 1'b0;
                state_q  <= (addr_sr_q == ADDRESS) ? StAddrAck : StWaitStop;
              end else begin
                addr_sr_q <= {addr_sr_q[5:0], sda};
                bit_cnt_q <= bit_cnt_q - 4'd1;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
                if (rw_q == RwRead) tx_sr_q <= data_fetch;
              end else begin
                ack_on_q   <= 1'b0;
                byte_idx_q <= '0;
                bit_cnt_q  <= 4'd7;
                if (rw_q == RwRead) begin
                  // The ACK-ending fall also launches the first read bit.
                  sda_oe_q <= ~tx_sr_q[W-1];
                  tx_sr_q  <= {tx_sr_q[W-2:0], 1'b0};
                  state_q  <= StRdByte;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= StWrByte;
                end
              end
            end
          end
          StWrByte: begin
            if (scl_rise) begin
              rx_sr_q <= {rx_sr_q[W-2:0], sda};
              if (bit_cnt_q == 4'd0) begin
                ack_on_q <= 1'b0;
                state_q  <= StWrAck;
              end else begin
                bit_cnt_q <= bit_cnt_q - 4'd1;
              end
            end
          end
          StWrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                ack_on_q  <= 1'b0;
                bit_cnt_q <= 4'd7;
                state_q   <= StWrByte;
                if (byte_idx_q == LastIdx) begin
                  data_send_q <= rx_sr_q;
                  rx_valid_q  <= 1'b1;
                  byte_idx_q  <= '0;
                end else begin
                  byte_idx_q <= byte_idx_q + 1'b1;
                end
              end
            end
          end
          StRdByte: begin
            // bit_cnt_q counts bits still to drive; zero means release for the master ACK.
            if (scl_fall) begin
              if (bit_cnt_q != 4'd0) begin
                sda_oe_q  <= ~tx_sr_q[W-1];
                tx_sr_q   <= {tx_sr_q[W-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q - 4'd1;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= StRdAck;
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (sda) begin
                tx_done_q <= 1'b1;
                state_q   <= StWaitStop;
              end else begin
                bit_cnt_q <= 4'd8;
                state_q   <= StRdByte;
                if (byte_idx_q == LastIdx) begin
                  tx_done_q  <= 1'b1;
                  tx_sr_q    <= data_fetch;
                  byte_idx_q <= '0;
                end else begin
                  byte_idx_q <= byte_idx_q + 1'b1;
                end
              end
            end
          end
          StIdle, StWaitStop: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign data_send = data_send_q;
  assign rx_valid  = rx_valid_q;
  assign tx_done   = tx_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_sync.sv
// Bus-level bench: a bit-banged I2C master against i2c_target_sync with a word-level model.
module tb_i2c_target_sync;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic [31:0] data_fetch = 32'h0;
  logic        sda_oe, rx_valid, tx_done, busy;
  logic [31:0] data_send;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int oe_cnt = 0;
  logic [31:0] exp_send = 32'h0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_sync #(
    .ADDRESS    (7'h2A),
    .DATA_BYTES (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .data_fetch(data_fetch),
    .data_send (data_send),
    .rx_valid  (rx_valid),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (tx_done)  tx_cnt <= tx_cnt + 1;
    if (sda_oe)   oe_cnt <= oe_cnt + 1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      sda_m = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
    end
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    b = sda_line; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  // ack returns the line level in the ninth slot: 0 = target ACKed.
  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({sda_oe, rx_valid, tx_done, busy} !== 4'b0000 || data_send !== 32'h0) begin
      errors++;
      $display("FAIL reset: got oe/rxv/txd/busy=%b data_send=%h want 0000 and 0",
               {sda_oe, rx_valid, tx_done, busy}, data_send);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_write_word(input logic [31:0] w);
    logic ack;
    int   rx0;
    rx0 = rx_cnt;
    start_cond();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'h54, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
    for (int i = 0; i < 4; i++) begin
      write_byte(w[31-8*i -: 8], ack);
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL wr_data_ack[%0d]: got %b want 0", i, ack);
      end
    end
    stop_cond();
    exp_send = w;
    checks++;
    if (data_send !== exp_send) begin
      errors++;
      $display("FAIL wr_data_send: got %h want %h", data_send, exp_send);
    end
    checks++;
    if (rx_cnt - rx0 != 1) begin
      errors++;
      $display("FAIL wr_rx_valid_pulses: got %0d want 1", rx_cnt - rx0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic do_read_word(input logic [31:0] w);
    logic       ack;
    logic [7:0] d;
    int         tx0;
    tx0 = tx_cnt;
    data_fetch = w;
    start_cond();
    write_byte(8'h55, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    for (int i = 0; i < 4; i++) begin
      read_byte(d, (i == 3));
      checks++;
      if (d !== w[31-8*i -: 8]) begin
        errors++;
        $display("FAIL rd_byte[%0d]: got %h want %h", i, d, w[31-8*i -: 8]);
      end
    end
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); end
    checks++;
    if (tx_cnt - tx0 != 1) begin
      errors++;
      $display("FAIL rd_tx_done_pulses: got %0d want 1", tx_cnt - tx0);
    end
    stop_cond();
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int   oe0;
    oe0 = oe_cnt;
    start_cond();
    write_byte(8'h56, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL bad_addr_nack: got %b want 1", ack); end
    write_byte(8'h99, ack);
    stop_cond();
    checks++;
    if (oe_cnt != oe0) begin
      errors++;
      $display("FAIL bad_addr_oe_cycles: got %0d want 0", oe_cnt - oe0);
    end
    checks++;
    if (data_send !== exp_send) begin
      errors++;
      $display("FAIL bad_addr_data_send: got %h want %h", data_send, exp_send);
    end
  endtask

  task automatic test_partial_write();
    logic ack;
    int   rx0;
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'h54, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL partial_ack: got %b want 0", ack); end
    stop_cond();
    checks++;
    if (rx_cnt != rx0) begin
      errors++;
      $display("FAIL partial_rx_valid: got %0d pulses want 0", rx_cnt - rx0);
    end
    checks++;
    if (data_send !== exp_send) begin
      errors++;
      $display("FAIL partial_data_send: got %h want %h", data_send, exp_send);
    end
  endtask

  task automatic test_repeated_start();
    logic        ack;
    logic [7:0]  d;
    logic [31:0] snap;
    int          rx0, tx0;
    rx0  = rx_cnt;
    tx0  = tx_cnt;
    snap = $urandom;
    data_fetch = ~snap;
    start_cond();
    write_byte(8'h54, ack);
    write_byte(8'hAA, ack);
    data_fetch = snap;
    start_cond();
    write_byte(8'h55, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
    data_fetch = $urandom;  // changes after the snapshot must not leak into the word
    for (int i = 0; i < 4; i++) begin
      read_byte(d, (i == 3));
      checks++;
      if (d !== snap[31-8*i -: 8]) begin
        errors++;
        $display("FAIL rs_byte[%0d]: got %h want %h", i, d, snap[31-8*i -: 8]);
      end
    end
    stop_cond();
    checks++;
    if (rx_cnt != rx0 || data_send !== exp_send) begin
      errors++;
      $display("FAIL rs_abandoned_write: got %0d pulses data_send=%h want 0 and %h",
               rx_cnt - rx0, data_send, exp_send);
    end
    checks++;
    if (tx_cnt - tx0 != 1) begin
      errors++;
      $display("FAIL rs_tx_done_pulses: got %0d want 1", tx_cnt - tx0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    int   oe0;
    int   n;
    data_fetch = 32'h00FF00FF;  // first bit is 0, so the target pulls SDA low
    start_cond();
    write_byte(8'h55, ack);
    n = 0;
    while (sda_oe !== 1'b1 && n < 4 * Q) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_read_drive: got %b want 1", sda_oe); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_release: got oe=%b busy=%b want 0 0", sda_oe, busy);
    end
    exp_send = 32'h0;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    oe0 = oe_cnt;
    write_byte(8'h54, ack);
    write_byte(8'h00, ack);
    checks++;
    if (oe_cnt != oe0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got oe_cycles=%0d busy=%b want 0 0", oe_cnt - oe0, busy);
    end
    checks++;
    if (data_send !== exp_send) begin
      errors++;
      $display("FAIL post_reset_data_send: got %h want %h", data_send, exp_send);
    end
    stop_cond();
    do_write_word($urandom);
  endtask

  initial begin
    test_reset();
    do_write_word(32'hDEADBEEF);
    do_read_word(32'hCAFE0123);
    test_wrong_addr();
    test_partial_write();
    test_repeated_start();
    for (int k = 0; k < 3; k++) begin
      do_write_word($urandom);
      do_read_word($urandom);
    end
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
